// File: rtl/sin_phase_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sin_phase_seq_pkg
// Brief    : Shared defaults, FSM state encodings and quadrant bit positions
//            for the sine voice phase sequencer.
// Revision : 1.0  initial release
// ============================================================================
package sin_phase_seq_pkg;

    // Default geometry: 16-bit phase accumulator feeding a 32 x 6 quarter-wave ROM
    localparam int ACC_W_DFLT  = 16;
    localparam int ROM_AW_DFLT = 5;
    localparam int ROM_DW_DFLT = 6;

    // Sequencer states (2-bit encoding)
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_OUT  = 2'd3;

    // Quadrant field: bit 0 mirrors the ROM index, bit 1 negates the sample
    localparam int c_QUAD_MIRROR_BIT = 0;
    localparam int c_QUAD_NEG_BIT    = 1;

endpackage : sin_phase_seq_pkg
`default_nettype wire

// File: rtl/sin_phase_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sin_phase_seq_if
// Brief    : Control / ROM / sample bundle of the sine phase sequencer.
//            Optional macro SIN_PHASE_SYNC_EN adds the phase_sync input.
// Revision : 1.0  initial release
// ============================================================================
interface sin_phase_seq_if
    import sin_phase_seq_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DFLT,
    parameter int ROM_AW = ROM_AW_DFLT,
    parameter int ROM_DW = ROM_DW_DFLT
);

    logic              en;
    logic              sample_tick;
    logic [ACC_W-1:0]  freq_word;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [ROM_DW-1:0] rom_data;
    logic [ROM_DW:0]   sample_out;
    logic              sample_valid;
    logic              tick_drop;
`ifdef SIN_PHASE_SYNC_EN
    logic              phase_sync;
`endif

    // Controller / ROM side
    modport master (
`ifdef SIN_PHASE_SYNC_EN
        output phase_sync,
`endif
        output en, sample_tick, freq_word, rom_data,
        input  rom_en, rom_addr, sample_out, sample_valid, tick_drop
    );

    // Sequencer side
    modport slave (
`ifdef SIN_PHASE_SYNC_EN
        input  phase_sync,
`endif
        input  en, sample_tick, freq_word, rom_data,
        output rom_en, rom_addr, sample_out, sample_valid, tick_drop
    );

endinterface : sin_phase_seq_if
`default_nettype wire

// File: rtl/sin_phase_seq_acc.sv
`default_nettype none
// ============================================================================
// Module   : sin_phase_acc
// Brief    : Phase accumulator register with load-zero and advance controls.
//            Exposes only the top PH_W bits used for ROM addressing.
// Revision : 1.0  initial release
// ============================================================================
module sin_phase_acc
    import sin_phase_seq_pkg::*;
#(
    parameter int ACC_W = ACC_W_DFLT,
    parameter int PH_W  = ROM_AW_DFLT + 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load_zero,
    input  wire logic             i_advance,
    input  wire logic [ACC_W-1:0] i_freq_word,
    output logic      [PH_W-1:0]  o_phase
);

    logic [ACC_W-1:0] r_acc;

    // Load-zero wins over advance; advance wraps modulo 2^ACC_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_load_zero) begin
            r_acc <= '0;
        end else if (i_advance) begin
            r_acc <= r_acc + i_freq_word;
        end
    end

    assign o_phase = r_acc[ACC_W-1 -: PH_W];

endmodule : sin_phase_acc
`default_nettype wire

// File: rtl/sin_phase_seq.sv
`default_nettype none
// ============================================================================
// Module   : sin_phase_seq
// Brief    : Phase accumulator and quadrant sequencer for the sine voice.
//            Drives a quarter-wave ROM (1-cycle read latency) and rebuilds a
//            signed full-wave sample by index mirroring and negation.
//            Optional macro SIN_PHASE_SYNC_EN adds phase_sync (acc reset).
// Revision : 1.0  initial release
// ============================================================================
module sin_phase_seq
    import sin_phase_seq_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DFLT,
    parameter int ROM_AW = ROM_AW_DFLT,
    parameter int ROM_DW = ROM_DW_DFLT
) (
    input  wire logic      clk,
    input  wire logic      rst,
    sin_phase_seq_if.slave bus
);

    localparam int PH_W = ROM_AW + 2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [PH_W-1:0]   w_phase;
    logic [1:0]        w_quad;
    logic [ROM_AW-1:0] w_idx;
    logic              w_sync;
    logic              w_busy;
    logic              w_advance;
    logic [ROM_DW:0]   w_mag;
    logic [ROM_DW:0]   w_mag_neg;

    logic              r_rom_en,   w_rom_en_nxt;
    logic [ROM_AW-1:0] r_rom_addr, w_rom_addr_nxt;
    logic [1:0]        r_quad_q,   w_quad_q_nxt;
    logic [ROM_DW:0]   r_sample,   w_sample_nxt;
    logic              r_valid,    w_valid_nxt;
    logic              r_drop,     w_drop_nxt;

`ifdef SIN_PHASE_SYNC_EN
    assign w_sync = bus.phase_sync;
`else
    assign w_sync = 1'b0;
`endif

    // A tick is only taken in IDLE while enabled and not overridden by sync
    assign w_busy    = (r_state != c_ST_IDLE);
    assign w_advance = bus.en & bus.sample_tick & ~w_busy & ~w_sync;

    sin_phase_acc #(
        .ACC_W (ACC_W),
        .PH_W  (PH_W)
    ) u_acc (
        .clk         (clk),
        .rst         (rst),
        .i_load_zero (w_sync),
        .i_advance   (w_advance),
        .i_freq_word (bus.freq_word),
        .o_phase     (w_phase)
    );

    assign w_quad    = w_phase[PH_W-1 -: 2];
    assign w_idx     = w_phase[ROM_AW-1:0];
    assign w_mag     = {1'b0, bus.rom_data};
    assign w_mag_neg = '0 - w_mag;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: sync or disable abort to IDLE, otherwise walk the sequence
    always_comb begin
        w_state_nxt = r_state;
        if (w_sync || !bus.en) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (bus.sample_tick) w_state_nxt = c_ST_ADDR;
                c_ST_ADDR: w_state_nxt = c_ST_WAIT;
                c_ST_WAIT: w_state_nxt = c_ST_OUT;
                c_ST_OUT:  w_state_nxt = c_ST_IDLE;
                default:   w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Output next-values: address mirroring, ROM enable, sign rebuild, pulses
    always_comb begin
        w_rom_en_nxt   = r_rom_en;
        w_rom_addr_nxt = r_rom_addr;
        w_quad_q_nxt   = r_quad_q;
        w_sample_nxt   = r_sample;
        w_valid_nxt    = 1'b0;
        w_drop_nxt     = 1'b0;
        if (w_sync) begin
            // Sync keeps the last sample on the output but abandons the read
            w_rom_en_nxt = 1'b0;
        end else if (!bus.en) begin
            w_rom_en_nxt = 1'b0;
            w_sample_nxt = '0;
        end else begin
            w_drop_nxt = bus.sample_tick & w_busy;
            case (r_state)
                c_ST_ADDR: begin
                    w_rom_addr_nxt = w_quad[c_QUAD_MIRROR_BIT] ? ~w_idx : w_idx;
                    w_quad_q_nxt   = w_quad;
                    w_rom_en_nxt   = 1'b1;
                end
                c_ST_WAIT: begin
                    w_rom_en_nxt = 1'b1;
                end
                c_ST_OUT: begin
                    w_sample_nxt = r_quad_q[c_QUAD_NEG_BIT] ? w_mag_neg : w_mag;
                    w_valid_nxt  = 1'b1;
                    w_rom_en_nxt = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_quad_q   <= '0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_rom_en   <= w_rom_en_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_quad_q   <= w_quad_q_nxt;
            r_sample   <= w_sample_nxt;
            r_valid    <= w_valid_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    assign bus.rom_en       = r_rom_en;
    assign bus.rom_addr     = r_rom_addr;
    assign bus.sample_out   = r_sample;
    assign bus.sample_valid = r_valid;
    assign bus.tick_drop    = r_drop;

endmodule : sin_phase_seq
`default_nettype wire

// File: tb/tb_sin_phase_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sin_phase_seq
// Brief    : Directed self-checking bench for sin_phase_seq with a
//            quarter-wave ROM model (1-cycle registered read).
// Revision : 1.0  initial release
// ============================================================================
module tb_sin_phase_seq;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    // round(31 * sin(pi/2 * i/31))
    logic [5:0] c_rom [0:31] = '{
        6'd0,  6'd2,  6'd3,  6'd5,  6'd6,  6'd8,  6'd9,  6'd11,
        6'd12, 6'd14, 6'd15, 6'd16, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd24, 6'd25, 6'd25, 6'd26, 6'd27, 6'd28, 6'd28,
        6'd29, 6'd30, 6'd30, 6'd30, 6'd31, 6'd31, 6'd31, 6'd31
    };

    sin_phase_seq_if bus_if ();

    sin_phase_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: registered output, 1-cycle latency
    always @(posedge clk) begin
        if (rst) bus_if.rom_data <= 6'd0;
        else if (bus_if.rom_en) bus_if.rom_data <= c_rom[bus_if.rom_addr];
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tick(input logic [15:0] f);
        bus_if.freq_word   = f;
        bus_if.sample_tick = 1'b1;
        step(1);
        bus_if.sample_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_cmp++; if (bus_if.rom_en !== 1'b0) begin n_bad++; $display("FAIL reset_rom_en: got %b expected 0", bus_if.rom_en); end
        n_cmp++; if (bus_if.rom_addr !== 5'd0) begin n_bad++; $display("FAIL reset_rom_addr: got %0d expected 0", bus_if.rom_addr); end
        n_cmp++; if (bus_if.sample_out !== 7'd0) begin n_bad++; $display("FAIL reset_sample: got %0d expected 0", bus_if.sample_out); end
        n_cmp++; if (bus_if.sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus_if.sample_valid); end
        n_cmp++; if (bus_if.tick_drop !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got %b expected 0", bus_if.tick_drop); end
        rst = 1'b0;
        bus_if.en = 1'b1;
        // acc 0x4400 -> phase 34: quad 1, idx 2 -> addr 29 -> +31
        send_tick(16'h4400);
        step(3);
        n_cmp++; if ($signed(bus_if.sample_out) !== 7'sd31) begin n_bad++; $display("FAIL pre_reset_sample: got %0d expected 31", $signed(bus_if.sample_out)); end
        // acc 0x4600 -> phase 35 -> addr 28; reset while in WAIT
        send_tick(16'h0200);
        step(1);
        n_cmp++; if (bus_if.rom_addr !== 5'd28) begin n_bad++; $display("FAIL pre_reset_addr: got %0d expected 28", bus_if.rom_addr); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus_if.rom_en !== 1'b0) begin n_bad++; $display("FAIL async_rom_en: got %b expected 0", bus_if.rom_en); end
        n_cmp++; if (bus_if.rom_addr !== 5'd0) begin n_bad++; $display("FAIL async_rom_addr: got %0d expected 0", bus_if.rom_addr); end
        n_cmp++; if (bus_if.sample_out !== 7'd0) begin n_bad++; $display("FAIL async_sample: got %0d expected 0", bus_if.sample_out); end
        n_cmp++; if (dut.u_acc.r_acc !== 16'h0000) begin n_bad++; $display("FAIL async_acc: got %h expected 0000", dut.u_acc.r_acc); end
        n_cmp++; if (dut.r_state !== 2'd0) begin n_bad++; $display("FAIL async_state: got %0d expected 0", dut.r_state); end
        step(1);
        rst = 1'b0;
        step(1);
        n_cmp++; if (bus_if.sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_discard_valid: got %b expected 0", bus_if.sample_valid); end
    endtask

    task automatic test_sequence();
        int exp_addr [4] = '{1, 2, 3, 4};
        int exp_smp  [4] = '{2, 3, 5, 6};
        do_reset();
        bus_if.en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_tick(16'h0200);
            step(1);
            n_cmp++; if (bus_if.rom_addr !== 5'(exp_addr[k])) begin n_bad++; $display("FAIL seq_addr[%0d]: got %0d expected %0d", k, bus_if.rom_addr, exp_addr[k]); end
            n_cmp++; if (bus_if.rom_en !== 1'b1) begin n_bad++; $display("FAIL seq_rom_en[%0d]: got %b expected 1", k, bus_if.rom_en); end
            step(1);
            n_cmp++; if (bus_if.sample_valid !== 1'b0) begin n_bad++; $display("FAIL seq_early_valid[%0d]: got %b expected 0", k, bus_if.sample_valid); end
            step(1);
            n_cmp++; if (bus_if.sample_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, bus_if.sample_valid); end
            n_cmp++; if (bus_if.sample_out !== 7'(exp_smp[k])) begin n_bad++; $display("FAIL seq_sample[%0d]: got %0d expected %0d", k, bus_if.sample_out, exp_smp[k]); end
        end
    endtask

    task automatic test_full_period();
        int nvalid;
        nvalid = 0;
        do_reset();
        bus_if.en = 1'b1;
        for (int t = 1; t <= 128; t++) begin
            send_tick(16'h0200);
            step(3);
            if (bus_if.sample_valid === 1'b1) nvalid++;
            if (t == 16) begin
                n_cmp++; if ($signed(bus_if.sample_out) !== 7'sd22) begin n_bad++; $display("FAIL period_t16: got %0d expected 22", $signed(bus_if.sample_out)); end
            end
            if (t == 32) begin
                n_cmp++; if ($signed(bus_if.sample_out) !== 7'sd31) begin n_bad++; $display("FAIL period_t32: got %0d expected 31", $signed(bus_if.sample_out)); end
            end
            if (t == 64) begin
                n_cmp++; if ($signed(bus_if.sample_out) !== 7'sd0) begin n_bad++; $display("FAIL period_t64: got %0d expected 0", $signed(bus_if.sample_out)); end
            end
            if (t == 96) begin
                n_cmp++; if ($signed(bus_if.sample_out) !== -7'sd31) begin n_bad++; $display("FAIL period_t96: got %0d expected -31", $signed(bus_if.sample_out)); end
            end
            if (t == 128) begin
                n_cmp++; if ($signed(bus_if.sample_out) !== 7'sd0) begin n_bad++; $display("FAIL period_t128: got %0d expected 0", $signed(bus_if.sample_out)); end
            end
        end
        n_cmp++; if (dut.u_acc.r_acc !== 16'h0000) begin n_bad++; $display("FAIL period_acc: got %h expected 0000", dut.u_acc.r_acc); end
        n_cmp++; if (nvalid != 128) begin n_bad++; $display("FAIL period_valid_count: got %0d expected 128", nvalid); end
    endtask

    task automatic test_wrap_drop();
        do_reset();
        bus_if.en = 1'b1;
        send_tick(16'h0001);
        step(3);
        n_cmp++; if (dut.u_acc.r_acc !== 16'h0001) begin n_bad++; $display("FAIL wrap_pre_acc: got %h expected 0001", dut.u_acc.r_acc); end
        send_tick(16'hFFFF);
        n_cmp++; if (dut.u_acc.r_acc !== 16'h0000) begin n_bad++; $display("FAIL wrap_acc: got %h expected 0000", dut.u_acc.r_acc); end
        step(1);
        // tick arriving in WAIT must be dropped
        bus_if.freq_word   = 16'h0200;
        bus_if.sample_tick = 1'b1;
        step(1);
        bus_if.sample_tick = 1'b0;
        n_cmp++; if (bus_if.tick_drop !== 1'b1) begin n_bad++; $display("FAIL drop_pulse: got %b expected 1", bus_if.tick_drop); end
        n_cmp++; if (dut.u_acc.r_acc !== 16'h0000) begin n_bad++; $display("FAIL drop_acc: got %h expected 0000", dut.u_acc.r_acc); end
        step(1);
        n_cmp++; if (bus_if.tick_drop !== 1'b0) begin n_bad++; $display("FAIL drop_one_cycle: got %b expected 0", bus_if.tick_drop); end
        n_cmp++; if (bus_if.sample_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid: got %b expected 1", bus_if.sample_valid); end
        n_cmp++; if (bus_if.sample_out !== 7'd0) begin n_bad++; $display("FAIL wrap_sample: got %0d expected 0", bus_if.sample_out); end
    endtask

    task automatic test_en_drop();
        do_reset();
        bus_if.en = 1'b1;
        send_tick(16'h0200);
        step(3);
        n_cmp++; if (bus_if.sample_out !== 7'd2) begin n_bad++; $display("FAIL en_pre_sample: got %0d expected 2", bus_if.sample_out); end
        send_tick(16'h0200);
        step(1);
        bus_if.en = 1'b0;
        step(1);
        n_cmp++; if (bus_if.rom_en !== 1'b0) begin n_bad++; $display("FAIL en_rom_en: got %b expected 0", bus_if.rom_en); end
        n_cmp++; if (bus_if.sample_out !== 7'd0) begin n_bad++; $display("FAIL en_sample: got %0d expected 0", bus_if.sample_out); end
        n_cmp++; if (dut.r_state !== 2'd0) begin n_bad++; $display("FAIL en_state: got %0d expected 0", dut.r_state); end
        step(1);
        n_cmp++; if (bus_if.sample_valid !== 1'b0) begin n_bad++; $display("FAIL en_no_valid: got %b expected 0", bus_if.sample_valid); end
        // tick while disabled in IDLE: no effect, no drop
        bus_if.sample_tick = 1'b1;
        step(1);
        bus_if.sample_tick = 1'b0;
        n_cmp++; if (bus_if.tick_drop !== 1'b0) begin n_bad++; $display("FAIL en_idle_drop: got %b expected 0", bus_if.tick_drop); end
        n_cmp++; if (dut.u_acc.r_acc !== 16'h0400) begin n_bad++; $display("FAIL en_held_acc: got %h expected 0400", dut.u_acc.r_acc); end
        bus_if.en = 1'b1;
        send_tick(16'h0200);
        step(3);
        n_cmp++; if (bus_if.sample_valid !== 1'b1) begin n_bad++; $display("FAIL en_resume_valid: got %b expected 1", bus_if.sample_valid); end
        n_cmp++; if (bus_if.sample_out !== 7'd5) begin n_bad++; $display("FAIL en_resume_sample: got %0d expected 5", bus_if.sample_out); end
    endtask

`ifdef SIN_PHASE_SYNC_EN
    task automatic test_phase_sync();
        int nvalid;
        nvalid = 0;
        do_reset();
        bus_if.en = 1'b1;
        send_tick(16'h4400);
        step(3);
        bus_if.phase_sync  = 1'b1;
        bus_if.freq_word   = 16'h0200;
        bus_if.sample_tick = 1'b1;
        step(1);
        bus_if.phase_sync  = 1'b0;
        bus_if.sample_tick = 1'b0;
        n_cmp++; if (dut.u_acc.r_acc !== 16'h0000) begin n_bad++; $display("FAIL sync_acc: got %h expected 0000", dut.u_acc.r_acc); end
        n_cmp++; if (dut.r_state !== 2'd0) begin n_bad++; $display("FAIL sync_state: got %0d expected 0", dut.r_state); end
        n_cmp++; if (bus_if.tick_drop !== 1'b0) begin n_bad++; $display("FAIL sync_drop: got %b expected 0", bus_if.tick_drop); end
        n_cmp++; if ($signed(bus_if.sample_out) !== 7'sd31) begin n_bad++; $display("FAIL sync_sample_hold: got %0d expected 31", $signed(bus_if.sample_out)); end
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (bus_if.sample_valid === 1'b1) nvalid++;
        end
        n_cmp++; if (nvalid != 0) begin n_bad++; $display("FAIL sync_no_sample: got %0d expected 0", nvalid); end
    endtask
`endif

    initial begin
        n_cmp              = 0;
        n_bad              = 0;
        rst                = 1'b1;
        bus_if.en          = 1'b0;
        bus_if.sample_tick = 1'b0;
        bus_if.freq_word   = 16'h0000;
`ifdef SIN_PHASE_SYNC_EN
        bus_if.phase_sync  = 1'b0;
`endif
        test_reset();
        test_sequence();
        test_full_period();
        test_wrap_drop();
        test_en_drop();
`ifdef SIN_PHASE_SYNC_EN
        test_phase_sync();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sin_phase_seq
`default_nettype wire
